// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: register map, STATUS/CONTROL
// bit positions and the {channel, register} address split.
package multi_timer_pkg;

  localparam int REG_SEL_W = 3;

  typedef enum logic [REG_SEL_W-1:0] {
    REG_STATUS   = 3'd0,
    REG_CONTROL  = 3'd1,
    REG_PERIOD   = 3'd2,
    REG_PRESCALE = 3'd3,
    REG_SNAP     = 3'd4,
    REG_COUNT    = 3'd5,
    REG_COMPARE  = 3'd6,
    REG_RSVD     = 3'd7
  } reg_e;

  localparam int ST_TO     = 0;
  localparam int ST_RUN    = 1;
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // Width of the channel-select field; a single channel still gets a 1-bit index.
  function automatic int ch_bits(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, down-counter, register file and interrupt.
// MULTI_TIMER_PWM_EN adds the COMPARE register and a registered PWM output.
module multi_timer_channel
  import multi_timer_pkg::*;
#(
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter int unsigned PERIOD_RST = 49999
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        wr_i,
  input  logic [2:0]  reg_sel_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
`ifdef MULTI_TIMER_PWM_EN
  ,
  output logic        pwm_o
`endif
);

  reg_e             sel;
  logic [CNT_W-1:0] counter_q, counter_d, period_q, period_d, snap_q, snap_d;
  logic [PRE_W-1:0] prescale_q, prescale_d, pre_cnt_q, pre_cnt_d;
  logic             run_q, run_d, to_q, to_d, cont_q, cont_d, ito_q, ito_d;
  logic             zero_prev_q, load_q, load_d;
  logic             wr_status, wr_control, wr_period, wr_prescale, wr_snap;
  logic             tick, at_zero, to_event;

  assign sel         = reg_e'(reg_sel_i);
  assign wr_status   = wr_i && (sel == REG_STATUS);
  assign wr_control  = wr_i && (sel == REG_CONTROL);
  assign wr_period   = wr_i && (sel == REG_PERIOD);
  assign wr_prescale = wr_i && (sel == REG_PRESCALE);
  assign wr_snap     = wr_i && (sel == REG_SNAP);

  assign tick     = run_q && (pre_cnt_q >= prescale_q);
  assign at_zero  = (counter_q == '0);
  assign to_event = at_zero && !zero_prev_q;

  always_comb begin
    // NOTE: every next-state signal gets its hold value first so no path leaves it unassigned (no latches).
    counter_d  = counter_q;
    period_d   = period_q;
    prescale_d = prescale_q;
    pre_cnt_d  = pre_cnt_q;
    snap_d     = snap_q;
    run_d      = run_q;
    to_d       = to_q;
    cont_d     = cont_q;
    ito_d      = ito_q;
    load_d     = wr_period;

    if (run_q) pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
    if (tick) begin
      if (at_zero) begin
        counter_d = period_q;
        if (!cont_q) run_d = 1'b0;
      end else begin
        counter_d = counter_q - 1'b1;
      end
    end
    // A PERIOD write lands in period_q first; the counter picks it up a cycle later.
    if (load_q) begin
      counter_d = period_q;
      run_d     = 1'b0;
    end
    if (wr_period) begin
      period_d  = wdata_i[CNT_W-1:0];
      pre_cnt_d = '0;
    end
    if (wr_prescale) prescale_d = wdata_i[PRE_W-1:0];
    if (wr_control) begin
      cont_d = wdata_i[CTL_CONT];
      ito_d  = wdata_i[CTL_ITO];
      if (wdata_i[CTL_START]) begin
        run_d     = 1'b1;
        pre_cnt_d = '0;
      end else if (wdata_i[CTL_STOP]) begin
        run_d = 1'b0;
      end
    end
    if (wr_snap) snap_d = counter_q;
    if (wr_status) to_d = 1'b0;
    if (to_event) to_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      counter_q   <= CNT_W'(PERIOD_RST);
      period_q    <= CNT_W'(PERIOD_RST);
      prescale_q  <= '0;
      pre_cnt_q   <= '0;
      snap_q      <= '0;
      run_q       <= 1'b0;
      to_q        <= 1'b0;
      cont_q      <= 1'b0;
      ito_q       <= 1'b0;
      zero_prev_q <= 1'b1;
      load_q      <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
      counter_q   <= counter_d;
      period_q    <= period_d;
      prescale_q  <= prescale_d;
      pre_cnt_q   <= pre_cnt_d;
      snap_q      <= snap_d;
      run_q       <= run_d;
      to_q        <= to_d;
      cont_q      <= cont_d;
      ito_q       <= ito_d;
      zero_prev_q <= at_zero;
      load_q      <= load_d;
    end
  end

`ifdef MULTI_TIMER_PWM_EN
  logic [CNT_W-1:0] compare_q;
  logic             pwm_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      compare_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      if (wr_i && (sel == REG_COMPARE)) compare_q <= wdata_i[CNT_W-1:0];
      pwm_q <= run_q && (counter_q < compare_q);
    end
  end

  assign pwm_o = pwm_q;
`endif

  always_comb begin
    rdata_o = '0;
    case (sel)
      REG_STATUS:   rdata_o = {30'b0, run_q, to_q};
      REG_CONTROL:  rdata_o = {30'b0, cont_q, ito_q};
      REG_PERIOD:   rdata_o = 32'(period_q);
      REG_PRESCALE: rdata_o = 32'(prescale_q);
      REG_SNAP:     rdata_o = 32'(snap_q);
      REG_COUNT:    rdata_o = 32'(counter_q);
`ifdef MULTI_TIMER_PWM_EN
      REG_COMPARE:  rdata_o = 32'(compare_q);
`endif
      default:      rdata_o = '0;
    endcase
  end

  assign irq_o = to_q && ito_q;

endmodule

// File: rtl/multi_timer.sv
// NCH independent down-counting timers behind a {channel, register} bus with a
// registered read port. MULTI_TIMER_PWM_EN adds per-channel COMPARE and pwm_out.
module multi_timer
  import multi_timer_pkg::*;
#(
  parameter int          NCH        = 4,
  parameter int          CNT_W      = 32,
  parameter int          PRE_W      = 8,
  parameter int unsigned PERIOD_RST = 49999
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             chipselect,
  input  logic                             write_n,
  input  logic [REG_SEL_W+$clog2(NCH)-1:0] address,
  input  logic [31:0]                      writedata,
  output logic [31:0]                      readdata,
  output logic                             irq,
  output logic [NCH-1:0]                   irq_vec
`ifdef MULTI_TIMER_PWM_EN
  ,
  output logic [NCH-1:0]                   pwm_out
`endif
);

  localparam int CH_W = ch_bits(NCH);

  logic [CH_W-1:0] ch_sel;
  logic            wr_en;
  logic [31:0]     ch_rdata [NCH];
  logic [31:0]     readdata_q, readdata_d;

  if (NCH > 1) begin : g_multi
    assign ch_sel = address[REG_SEL_W +: CH_W];
  end else begin : g_single
    assign ch_sel = '0;
  end

  assign wr_en = chipselect && !write_n;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    multi_timer_channel #(
      .CNT_W      (CNT_W),
      .PRE_W      (PRE_W),
      .PERIOD_RST (PERIOD_RST)
    ) u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .wr_i      (wr_en && (int'(ch_sel) == i)),
      .reg_sel_i (address[REG_SEL_W-1:0]),
      .wdata_i   (writedata),
      .rdata_o   (ch_rdata[i]),
      .irq_o     (irq_vec[i])
`ifdef MULTI_TIMER_PWM_EN
      ,
      .pwm_o     (pwm_out[i])
`endif
    );
  end

  // Channel indices at or beyond NCH match nothing and read back zero.
  always_comb begin
    readdata_d = '0;
    for (int i = 0; i < NCH; i++) begin
      if (int'(ch_sel) == i) readdata_d = ch_rdata[i];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata_q <= '0;
    else          readdata_q <= readdata_d;
  end

  assign readdata = readdata_q;
  assign irq      = |irq_vec;

endmodule

// File: tb/tb_multi_timer.sv
// Scoreboard bench for multi_timer: stimulus queues expected read data and
// interrupt states, a monitor pops and compares them as the DUT presents them.
module tb_multi_timer;
  import multi_timer_pkg::*;

  localparam int NCH = 4;

  logic           clk        = 1'b0;
  logic           reset_n    = 1'b0;
  logic           chipselect = 1'b0;
  logic           write_n    = 1'b1;
  logic [4:0]     address    = '0;
  logic [31:0]    writedata  = '0;
  logic [31:0]    readdata;
  logic           irq;
  logic [NCH-1:0] irq_vec;
`ifdef MULTI_TIMER_PWM_EN
  logic [NCH-1:0] pwm_out;
`endif

  always #5 clk = ~clk;

  multi_timer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .chipselect (chipselect),
    .write_n    (write_n),
    .address    (address),
    .writedata  (writedata),
    .readdata   (readdata),
    .irq        (irq),
    .irq_vec    (irq_vec)
`ifdef MULTI_TIMER_PWM_EN
    ,
    .pwm_out    (pwm_out)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t mon_e;
  logic rd_issue  = 1'b0;
  logic rd_vld    = 1'b0;
  logic irq_issue = 1'b0;
  int   n_checks  = 0;
  int   n_pass    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // readdata is valid one clock after the address is presented.
  always @(posedge clk) rd_vld <= rd_issue;

  always @(negedge clk) begin
    #1;
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got read data 0x%0h with no expectation queued", readdata);
      end else begin
        mon_e = rd_q.pop_front();
        check(mon_e.name, readdata, mon_e.exp);
      end
    end
    if (irq_issue) begin
      if (irq_q.size() == 0) begin
        n_checks++;
        $display("FAIL irq_unexpected: got irq sample with no expectation queued");
      end else begin
        mon_e = irq_q.pop_front();
        check(mon_e.name, {27'b0, irq, irq_vec}, mon_e.exp);
      end
    end
  end

  function automatic logic [4:0] adr(input int ch, input logic [2:0] r);
    return {2'(ch), r};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string name);
    exp_t e;
    e.name   = name;
    e.exp    = exp;
    address  = a;
    rd_issue = 1'b1;
    rd_q.push_back(e);
    @(negedge clk);
    rd_issue = 1'b0;
  endtask

  // Expected {irq, irq_vec} at the current negedge.
  task automatic exp_irq(input logic [4:0] exp, input string name);
    exp_t e;
    e.name    = name;
    e.exp     = 32'(exp);
    irq_issue = 1'b1;
    irq_q.push_back(e);
    #2;
    irq_issue = 1'b0;
  endtask

  task automatic wait_vec(input int idx, input string name);
    int cnt = 0;
    while (irq_vec[idx] !== 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    n_checks++;
    if (cnt < 200) n_pass++;
    else $display("FAIL %s: got no interrupt on channel %0d within 200 cycles, expected one", name, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test by 200000 time units, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle(3);
    reset_n = 1'b1;
    idle(1);

    // Reset state
    exp_irq(5'b0, "rst_irq");
    rd(adr(1, REG_PERIOD),   32'd49999, "rst_period");
    rd(adr(1, REG_PRESCALE), 32'd0,     "rst_prescale");
    rd(adr(1, REG_CONTROL),  32'd0,     "rst_control");
    rd(adr(1, REG_STATUS),   32'd0,     "rst_status");
    rd(adr(1, REG_SNAP),     32'd0,     "rst_snap");
    rd(adr(1, REG_COUNT),    32'd49999, "rst_count");
    rd(adr(1, REG_RSVD),     32'd0,     "rst_reg7");
`ifndef MULTI_TIMER_PWM_EN
    wr(adr(1, REG_COMPARE), 32'd3);
    rd(adr(1, REG_COMPARE),  32'd0,     "reg6_absent");
`endif

    // ch0 one-shot: PERIOD=4, PRESCALE=0, START|ITO -> TO 5 cycles after START
    wr(adr(0, REG_PERIOD), 32'd4);
    wr(adr(0, REG_PRESCALE), 32'd0);
    wr(adr(0, REG_CONTROL), 32'h5);
    for (int k = 0; k < 5; k++) begin
      exp_irq(5'b0, "oneshot_pre_timeout");
      idle(1);
    end
    exp_irq(5'b1_0001, "oneshot_timeout");
    rd(adr(0, REG_STATUS),  32'h1, "oneshot_status");
    rd(adr(0, REG_COUNT),   32'd4, "oneshot_count_reload");
    rd(adr(0, REG_CONTROL), 32'h1, "oneshot_control_rb");
    wr(adr(0, REG_STATUS), 32'h0);
    exp_irq(5'b0, "oneshot_to_cleared");

    // ch2 continuous: PERIOD=2, PRESCALE=3 -> TO every 12 cycles; clear collides with event
    wr(adr(2, REG_PERIOD), 32'd2);
    wr(adr(2, REG_PRESCALE), 32'd3);
    wr(adr(2, REG_CONTROL), 32'h7);
    rd(adr(2, REG_CONTROL), 32'h3, "cont_control_rb");
    wait_vec(2, "cont_first_timeout");
    wr(adr(2, REG_STATUS), 32'h0);
    exp_irq(5'b0, "cont_cleared");
    idle(10);
    exp_irq(5'b0, "cont_before_event");
    wr(adr(2, REG_STATUS), 32'hFFFF_FFFF);
    exp_irq(5'b1_0100, "cont_event_beats_clear");
    rd(adr(2, REG_STATUS), 32'h3, "cont_status");
    wr(adr(2, REG_CONTROL), 32'h8);
    wr(adr(2, REG_STATUS), 32'h0);
    exp_irq(5'b0, "cont_stopped");

    // ch1 START+STOP together: START wins; later STOP freezes the count
    wr(adr(1, REG_PERIOD), 32'd1000);
    idle(1);
    wr(adr(1, REG_CONTROL), 32'hC);
    rd(adr(1, REG_STATUS), 32'h2, "startstop_run");
    wr(adr(1, REG_CONTROL), 32'h8);
    rd(adr(1, REG_COUNT), 32'd998, "stop_count");
    idle(3);
    rd(adr(1, REG_COUNT),  32'd998, "stop_count_holds");
    rd(adr(1, REG_STATUS), 32'h0,   "stop_status");

    // ch3 PERIOD write while running, then SNAP
    wr(adr(3, REG_PERIOD), 32'd50);
    idle(1);
    wr(adr(3, REG_CONTROL), 32'h4);
    idle(5);
    wr(adr(3, REG_PERIOD), 32'd100);
    idle(1);
    rd(adr(3, REG_STATUS), 32'h0,   "perwr_run_cleared");
    rd(adr(3, REG_COUNT),  32'd100, "perwr_count_loaded");
    wr(adr(3, REG_SNAP), 32'hDEAD_BEEF);
    rd(adr(3, REG_SNAP),   32'd100, "snap_capture");
    rd(adr(3, REG_PERIOD), 32'd100, "perwr_period_rb");

    // Reset mid-count on several running channels
    wr(adr(0, REG_PERIOD), 32'd3);
    wr(adr(1, REG_PERIOD), 32'd5);
    wr(adr(0, REG_CONTROL), 32'h7);
    wr(adr(1, REG_CONTROL), 32'h7);
    wr(adr(3, REG_CONTROL), 32'h4);
    wait_vec(0, "pre_reset_timeout");
    reset_n = 1'b0;
    exp_irq(5'b0, "in_reset_irq");
    rd(adr(0, REG_PERIOD), 32'd0, "in_reset_readdata");
    idle(2);
    reset_n = 1'b1;
    idle(1);
    rd(adr(0, REG_PERIOD),  32'd49999, "post_reset_period");
    rd(adr(0, REG_STATUS),  32'h0,     "post_reset_status");
    rd(adr(0, REG_COUNT),   32'd49999, "post_reset_count");
    rd(adr(1, REG_CONTROL), 32'h0,     "post_reset_control");
    idle(20);
    exp_irq(5'b0, "post_reset_quiet");

`ifdef MULTI_TIMER_PWM_EN
    // PWM: PERIOD=9, COMPARE=3, continuous -> high 3 of every 10 cycles
    begin
      int highs = 0;
      wr(adr(1, REG_PERIOD), 32'd9);
      idle(1);
      wr(adr(1, REG_COMPARE), 32'd3);
      rd(adr(1, REG_COMPARE), 32'd3, "pwm_compare_rb");
      wr(adr(1, REG_CONTROL), 32'h6);
      idle(12);
      for (int k = 0; k < 30; k++) begin
        if (pwm_out[1] === 1'b1) highs++;
        idle(1);
      end
      check("pwm_duty_30cyc", 32'(highs), 32'd9);
    end
`endif

    idle(3);
    check("rd_queue_drained",  32'(rd_q.size()),  32'd0);
    check("irq_queue_drained", 32'(irq_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/multi_timer.md
MULTI_TIMER -- requirements
Module: multi_timer

Interface
REQ-001 SHALL provide parameter NCH, default 4, number of independent timer channels (1..8).
REQ-002 SHALL provide parameter CNT_W, default 32, counter/period width in bits (8..32).
REQ-003 SHALL provide parameter PRE_W, default 8, prescaler width in bits.
REQ-004 SHALL provide parameter PERIOD_RST, default 49999, reset value of every PERIOD register.
REQ-005 SHALL have ports:
  clk  in  1  clock
  reset_n  in  1  asynchronous, active-low reset
  chipselect  in  1  slave select
  write_n  in  1  active-low write strobe
  address  in  3+clog2(NCH)  {channel, reg[2:0]}
  writedata  in  32  write data
  readdata  out  32  registered read data
  irq  out  1  OR of all channel interrupts
  irq_vec  out  NCH  per-channel interrupt
REQ-006 SHALL use reset reset_n, asynchronous, active-low; clock clk.

Function
REQ-007 Per-channel registers SHALL be: 0 STATUS {RUN[1],TO[0]}; 1 CONTROL {STOP[3],START[2],CONT[1],ITO[0]}; 2 PERIOD; 3 PRESCALE; 4 SNAP; 5 COUNT (live, read-only); 6/7 see REQ-020.
REQ-008 Write = chipselect & ~write_n; readdata SHALL update one clock after address, unused bits zero, unmapped/out-of-range channel reads zero.
REQ-009 CONTROL write SHALL store bits [1:0]; START=1 sets RUN; STOP=1 clears RUN; both set in one write: START wins.
REQ-010 Running counter SHALL decrement once per PRESCALE+1 clk cycles (prescale tick); PRESCALE=0 decrements every cycle; prescaler SHALL reset to 0 on START and PERIOD write.
REQ-011 On a tick with counter==0: reload PERIOD; if CONT=0 clear RUN in same cycle.
REQ-012 Timeout event SHALL be the rising edge of (counter==0); it sets TO exactly once per zero arrival.
REQ-013 STATUS write (any data) SHALL clear TO; simultaneous timeout event SHALL win (TO stays 1).
REQ-014 PERIOD write SHALL truncate to CNT_W, then next cycle load counter with new PERIOD and clear RUN.
REQ-015 SNAP write (any data) SHALL capture current counter into SNAP; SNAP read returns captured value.
REQ-016 irq_vec[i] SHALL equal TO[i] & ITO[i], combinational from registers; irq = |irq_vec.
REQ-017 Channels SHALL be fully independent; simultaneous events on different channels SHALL all be honoured.

Reset
REQ-018 On reset: counter=PERIOD=PERIOD_RST, PRESCALE=0, CONTROL=0, RUN=0, TO=0, SNAP=0, readdata=0, irq=0, irq_vec=0, prescaler=0.
REQ-019 Reset asserted mid-count SHALL abort immediately; no timeout event after release until START.

Configuration
REQ-020 With MULTI_TIMER_PWM_EN defined: reg 6 COMPARE (CNT_W, reset 0), port pwm_out[NCH] registered, pwm_out[i]=RUN[i] & (counter[i] < COMPARE[i]); without it: no pwm_out port, reg 6 reads zero, writes ignored.

Structure
REQ-021 Package multi_timer_pkg SHALL hold register offsets, CONTROL/STATUS bit indices, and address-decode constants.
REQ-022 Sub-module multi_timer_channel SHALL implement one channel (counter, prescaler, registers, irq); top SHALL instantiate NCH copies plus decode and read mux.

Verification
REQ-023 PERIOD=4, PRESCALE=0, CONTROL=0x5 on ch0 -> TO and irq assert 5 cycles after START; RUN clears (one-shot); COUNT reads 4.
REQ-024 ch2 PERIOD=2, PRESCALE=3, CONTROL=0x7 -> TO every 12 cycles; STATUS write coinciding with event leaves TO=1.
REQ-025 CONTROL=0xC -> RUN=1; subsequent 0x8 -> RUN=0, counter holds value.
REQ-026 PERIOD write while running (value 100) -> RUN=0 next cycle, COUNT=100; SNAP write then SNAP read =100.
REQ-027 Reset asserted mid-count on all channels -> all outputs zero, PERIOD reads 49999, irq=0 after release.
REQ-028 With MULTI_TIMER_PWM_EN, PERIOD=9, COMPARE=3, continuous -> pwm_out high 3 of every 10 cycles.
